// File: rtl/traffic_plan_gen.sv
// Averages per-frame vehicle counts over a window, classifies traffic flow with hysteresis,
// and commits the sampled level plus its red/green durations each time the light FSM asks.
module traffic_plan_gen #(
    parameter int WIN      = 8,
    parameter int TH_LM_UP = 32,
    parameter int TH_LM_DN = 24,
    parameter int TH_MH_UP = 64,
    parameter int TH_MH_DN = 48,
    parameter int RED_L    = 20,
    parameter int GREEN_L  = 10,
    parameter int RED_M    = 15,
    parameter int GREEN_M  = 15,
    parameter int RED_H    = 10,
    parameter int GREEN_H  = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        car_cnt_valid,
    input  logic [7:0]  car_cnt,
    input  logic        tr_valid,
    input  logic        light_valid,
    input  logic        o_tr_light,
    output logic [1:0]  traffic_sel,
    output logic [4:0]  howmany_count_red,
    output logic [4:0]  howmany_count_green,
    output logic [1:0]  active_level,
    output logic [7:0]  avg_count,
    output logic        avg_valid,
    output logic [15:0] cycle_cnt,
    output logic [15:0] green_cnt,
    output logic        proto_err
);

    localparam int LOG_WIN = $clog2(WIN);
    localparam int SUM_W   = 8 + LOG_WIN;

    localparam logic [7:0] LM_UP = 8'(TH_LM_UP);
    localparam logic [7:0] LM_DN = 8'(TH_LM_DN);
    localparam logic [7:0] MH_UP = 8'(TH_MH_UP);
    localparam logic [7:0] MH_DN = 8'(TH_MH_DN);

    typedef enum logic [1:0] {
        LVL_LOW  = 2'b00,
        LVL_MID  = 2'b01,
        LVL_HIGH = 2'b10
    } level_t;

    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   sum_next;
    logic [LOG_WIN-1:0] frame_idx;
    logic               last_frame;
    level_t             level_q;
    level_t             level_d;
    level_t             prev_sel;

    assign sum_next   = sum + SUM_W'(car_cnt);
    assign last_frame = (frame_idx == LOG_WIN'(WIN - 1));

    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum       <= '0;
            frame_idx <= '0;
            avg_count <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= car_cnt_valid && last_frame;
            if (car_cnt_valid) begin
                if (last_frame) begin
                    avg_count <= 8'(sum_next >> LOG_WIN);
                    sum       <= '0;
                    frame_idx <= '0;
                end else begin
                    sum       <= sum_next;
                    frame_idx <= frame_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_q <= LVL_LOW;
        else       level_q <= level_d;
    end

    // NOTE: level_d gets a default before any branch, so no latch is inferred.
    always_comb begin
        level_d = level_q;
        if (avg_valid) begin
            unique case (level_q)
                LVL_LOW: begin
                    if (avg_count >= MH_UP)      level_d = LVL_HIGH;
                    else if (avg_count >= LM_UP) level_d = LVL_MID;
                end
                LVL_MID: begin
                    if (avg_count >= MH_UP)      level_d = LVL_HIGH;
                    else if (avg_count < LM_DN)  level_d = LVL_LOW;
                end
                LVL_HIGH: begin
                    if (avg_count < LM_DN)       level_d = LVL_LOW;
                    else if (avg_count < MH_DN)  level_d = LVL_MID;
                end
                default: level_d = LVL_LOW;
            endcase
        end
    end

    assign traffic_sel = level_q;

    // prev_sel holds the level the FSM saw on the cycle before its tr_valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sel     <= LVL_LOW;
            active_level <= LVL_LOW;
            cycle_cnt    <= '0;
            green_cnt    <= '0;
            proto_err    <= 1'b0;
        end else begin
            prev_sel <= level_q;
            if (tr_valid) begin
                active_level <= prev_sel;
                cycle_cnt    <= cycle_cnt + 16'd1;
                if (o_tr_light) proto_err <= 1'b1;
            end
            if (light_valid && o_tr_light) green_cnt <= green_cnt + 16'd1;
        end
    end

    // Durations lag active_level by one cycle; the reset values keep them non-zero meanwhile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            howmany_count_red   <= 5'(RED_L);
            howmany_count_green <= 5'(GREEN_L);
        end else begin
            case (active_level)
                LVL_MID: begin
                    howmany_count_red   <= 5'(RED_M);
                    howmany_count_green <= 5'(GREEN_M);
                end
                LVL_HIGH: begin
                    howmany_count_red   <= 5'(RED_H);
                    howmany_count_green <= 5'(GREEN_H);
                end
                default: begin
                    howmany_count_red   <= 5'(RED_L);
                    howmany_count_green <= 5'(GREEN_L);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_plan_gen.sv
// Directed bench for traffic_plan_gen: a window/level reference model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_traffic_plan_gen;

    localparam int WIN = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        car_cnt_valid;
    logic [7:0]  car_cnt;
    logic        tr_valid;
    logic        light_valid;
    logic        o_tr_light;
    logic [1:0]  traffic_sel;
    logic [4:0]  howmany_count_red;
    logic [4:0]  howmany_count_green;
    logic [1:0]  active_level;
    logic [7:0]  avg_count;
    logic        avg_valid;
    logic [15:0] cycle_cnt;
    logic [15:0] green_cnt;
    logic        proto_err;

    traffic_plan_gen dut (
        .clk                 (clk),
        .reset               (reset),
        .car_cnt_valid       (car_cnt_valid),
        .car_cnt             (car_cnt),
        .tr_valid            (tr_valid),
        .light_valid         (light_valid),
        .o_tr_light          (o_tr_light),
        .traffic_sel         (traffic_sel),
        .howmany_count_red   (howmany_count_red),
        .howmany_count_green (howmany_count_green),
        .active_level        (active_level),
        .avg_count           (avg_count),
        .avg_valid           (avg_valid),
        .cycle_cnt           (cycle_cnt),
        .green_cnt           (green_cnt),
        .proto_err           (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: levels 0 LOW, 1 MID, 2 HIGH.
    function automatic int classify(input int lvl, input int a);
        if (lvl == 0) return (a >= 64) ? 2 : (a >= 32) ? 1 : 0;
        if (lvl == 1) return (a >= 64) ? 2 : (a < 24) ? 0 : 1;
        return (a < 24) ? 0 : (a < 48) ? 1 : 2;
    endfunction

    function automatic int red_of(input int lvl);
        return (lvl == 2) ? 10 : (lvl == 1) ? 15 : 20;
    endfunction

    function automatic int green_of(input int lvl);
        return (lvl == 2) ? 25 : (lvl == 1) ? 15 : 10;
    endfunction

    int          samples[$];
    int          m_avg, m_level, m_prev, m_active, m_red, m_green;
    bit          m_avg_valid, m_err;
    logic [15:0] m_cycle, m_gcnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            samples.delete();
            m_avg = 0; m_avg_valid = 0; m_level = 0; m_prev = 0; m_active = 0;
            m_red = 20; m_green = 10; m_cycle = 0; m_gcnt = 0; m_err = 0;
        end else begin
            int old_level, old_prev, old_active, tot;
            old_level  = m_level;
            old_prev   = m_prev;
            old_active = m_active;
            m_red   = red_of(old_active);
            m_green = green_of(old_active);
            if (tr_valid) begin
                m_active = old_prev;
                m_cycle  = m_cycle + 16'd1;
                if (o_tr_light) m_err = 1;
            end
            m_prev = old_level;
            if (m_avg_valid) m_level = classify(old_level, m_avg);
            m_avg_valid = 0;
            if (car_cnt_valid) begin
                samples.push_back(int'(car_cnt));
                if (samples.size() == WIN) begin
                    tot = 0;
                    foreach (samples[i]) tot += samples[i];
                    m_avg = tot / WIN;
                    m_avg_valid = 1;
                    samples.delete();
                end
            end
            if (light_valid && o_tr_light) m_gcnt = m_gcnt + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("traffic_sel", 32'(traffic_sel), 32'(m_level));
            check("active_level", 32'(active_level), 32'(m_active));
            check("red", 32'(howmany_count_red), 32'(m_red));
            check("green", 32'(howmany_count_green), 32'(m_green));
            check("avg_count", 32'(avg_count), 32'(m_avg));
            check("avg_valid", 32'(avg_valid), 32'(m_avg_valid));
            check("cycle_cnt", 32'(cycle_cnt), 32'(m_cycle));
            check("green_cnt", 32'(green_cnt), 32'(m_gcnt));
            check("proto_err", 32'(proto_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send_frame(input int v);
        car_cnt_valid = 1'b1;
        car_cnt       = 8'(v);
        tick();
        car_cnt_valid = 1'b0;
    endtask

    task automatic send_window(input int v);
        for (int i = 0; i < WIN; i++) send_frame(v);
    endtask

    task automatic pulse_tr(input logic light);
        tr_valid   = 1'b1;
        o_tr_light = light;
        tick();
        tr_valid   = 1'b0;
        o_tr_light = 1'b0;
    endtask

    int pat[8] = '{20, 36, 28, 28, 30, 26, 29, 34};
    int bv[9]  = '{48, 47, 63, 64, 24, 23, 31, 32, 23};
    int be[9]  = '{2, 1, 1, 2, 1, 0, 0, 1, 0};

    initial begin
        reset = 1'b1; car_cnt_valid = 1'b0; car_cnt = '0;
        tr_valid = 1'b0; light_valid = 1'b0; o_tr_light = 1'b0;
        #1;
        do_reset();
        check("rst traffic_sel", 32'(traffic_sel), 0);
        check("rst red", 32'(howmany_count_red), 20);
        check("rst green", 32'(howmany_count_green), 10);
        check("rst avg_valid", 32'(avg_valid), 0);
        check("rst cycle_cnt", 32'(cycle_cnt), 0);
        check("rst proto_err", 32'(proto_err), 0);

        // LOW -> MID with 8 x 40
        send_window(40);
        check("w40 avg", 32'(avg_count), 40);
        check("w40 avg_valid", 32'(avg_valid), 1);
        check("w40 sel before", 32'(traffic_sel), 0);
        tick();
        check("w40 avg_valid drop", 32'(avg_valid), 0);
        check("w40 sel", 32'(traffic_sel), 1);

        // MID, avg 231/8 truncates to 28 -> hold; sparse samples
        for (int i = 0; i < 8; i++) begin
            send_frame(pat[i]);
            if (i != 7) tick();
        end
        check("w28 avg", 32'(avg_count), 28);
        tick();
        check("w28 sel", 32'(traffic_sel), 1);
        send_window(20);
        tick();
        check("w20 sel", 32'(traffic_sel), 0);

        // LOW -> HIGH directly, then commit
        send_window(100);
        tick();
        check("w100 sel", 32'(traffic_sel), 2);
        tick();
        pulse_tr(1'b0);
        check("commit active", 32'(active_level), 2);
        check("commit red lag", 32'(howmany_count_red), 20);
        tick();
        check("commit red", 32'(howmany_count_red), 10);
        check("commit green", 32'(howmany_count_green), 25);

        // Hysteresis boundaries starting from HIGH
        for (int i = 0; i < 9; i++) begin
            send_window(bv[i]);
            tick();
            check($sformatf("bound %0d sel", bv[i]), 32'(traffic_sel), 32'(be[i]));
        end

        // Level change on the same edge as tr_valid
        do_reset();
        send_window(40);
        pulse_tr(1'b0);
        check("same-edge sel", 32'(traffic_sel), 1);
        check("same-edge active", 32'(active_level), 0);
        check("same-edge cycle", 32'(cycle_cnt), 1);
        tick();
        check("same-edge red", 32'(howmany_count_red), 20);
        check("same-edge green", 32'(howmany_count_green), 10);
        pulse_tr(1'b0);
        check("second active", 32'(active_level), 1);
        tick();
        check("second red", 32'(howmany_count_red), 15);
        check("second green", 32'(howmany_count_green), 15);

        // Green starts: red light_valid is ignored
        light_valid = 1'b1; o_tr_light = 1'b1;
        tick();
        o_tr_light = 1'b0;
        tick();
        light_valid = 1'b0;
        check("green_cnt", 32'(green_cnt), 1);

        // Protocol error is sticky
        pulse_tr(1'b1);
        check("proto_err set", 32'(proto_err), 1);
        check("proto cycle", 32'(cycle_cnt), 3);
        for (int i = 0; i < 3; i++) tick();
        check("proto_err held", 32'(proto_err), 1);

        // Reset mid-window drops the partial sum
        for (int i = 0; i < 3; i++) send_frame(200);
        do_reset();
        check("rst2 proto_err", 32'(proto_err), 0);
        check("rst2 green_cnt", 32'(green_cnt), 0);
        send_window(10);
        check("w10 avg", 32'(avg_count), 10);
        check("w10 avg_valid", 32'(avg_valid), 1);
        tick();
        check("w10 sel", 32'(traffic_sel), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
